// File: rtl/sw_pkg.sv
// Shared types and constants for the stopwatch run controller.
package sw_pkg;

  // Run FSM encoding; also driven out for the LED/debug display.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    LAP   = 2'd3
  } sw_state_t;

  // Highest value the counter chain may show, BCD mm:ss.cc = 99:59.99.
  localparam logic [23:0] MAX_BCD = 24'h99_59_99;

  // Registered control outputs toward the counters and display mux.
  typedef struct packed {
    logic tick_en;
    logic clr;
    logic freeze;
  } sw_out_t;

  // Prescaler modulus: system clocks per count-enable tick.
  function automatic int unsigned sw_div(input int unsigned clk_hz,
                                         input int unsigned tick_hz);
    return clk_hz / tick_hz;
  endfunction

endpackage

// File: rtl/sw_run_ctrl_if.sv
// Button/status inputs and control outputs of the run controller.
interface sw_run_ctrl_if;
  import sw_pkg::*;

  logic      btn_ss;
  logic      btn_lc;
  logic      at_max;
  logic      tick_en;
  logic      clr;
  logic      freeze;
  sw_state_t state;

  // Environment side: debouncers and counter chain.
  modport master (output btn_ss, btn_lc, at_max,
                  input  tick_en, clr, freeze, state);

  // Controller side.
  modport slave  (input  btn_ss, btn_lc, at_max,
                  output tick_en, clr, freeze, state);
endinterface

// File: rtl/sw_prescaler.sv
// Free-running 0..DIV-1 prescaler; holds when not running, zeroes on request.
module sw_prescaler #(
  parameter int unsigned DIV   = 500000,
  parameter int unsigned DIV_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic             zero,
  output logic             tick,
  output logic [DIV_W-1:0] count
);

  localparam logic [DIV_W-1:0] LAST = DIV_W'(DIV - 1);

  // Wrap pulse: terminal count reached while running.
  assign tick = run && (count == LAST);

  // Count only while running; holding otherwise keeps the phase across a pause.
  always_ff @(posedge clk) begin
    if (reset || zero)  count <= '0;
    else if (tick)      count <= '0;
    else if (run)       count <= count + DIV_W'(1);
  end

endmodule

// File: rtl/sw_run_ctrl.sv
// Run/pause/lap/clear controller for the stopwatch counter chain.
module sw_run_ctrl
  import sw_pkg::*;
#(
  parameter int unsigned CLK_HZ  = 50000000,
  parameter int unsigned TICK_HZ = 100,
  parameter int unsigned DIV_W   = 32
) (
  input  logic         clk,
  input  logic         reset,
  sw_run_ctrl_if.slave bus
);

  localparam int unsigned DIV = sw_div(CLK_HZ, TICK_HZ);

  sw_state_t        state_q, state_d;
  sw_out_t          out_q, out_d;
  logic             running;
  logic             wrap;
  logic             clr_d;
  // Phase stays private to the prescaler; nothing here needs it.
  logic [DIV_W-1:0] count_unused;

  assign running = (state_q == RUN) || (state_q == LAP);

  // Zeroing on any move into (or stay in) IDLE also lines it up with clr.
  sw_prescaler #(.DIV(DIV), .DIV_W(DIV_W)) u_pre (
    .clk   (clk),
    .reset (reset),
    .run   (running),
    .zero  (state_d == IDLE),
    .tick  (wrap),
    .count (count_unused)
  );

  // Next state: start/stop beats lap/clear; an at_max wrap overrides both.
  always_comb begin
    state_d = state_q;
    clr_d   = 1'b0;
    case (state_q)
      IDLE:  if (bus.btn_ss)      state_d = RUN;
             else if (bus.btn_lc) clr_d   = 1'b1;
      RUN:   if (bus.btn_ss)      state_d = PAUSE;
             else if (bus.btn_lc) state_d = LAP;
      LAP:   if (bus.btn_ss)      state_d = PAUSE;
             else if (bus.btn_lc) state_d = RUN;
      PAUSE: if (bus.btn_ss)      state_d = RUN;
             else if (bus.btn_lc) begin
               state_d = IDLE;
               clr_d   = 1'b1;
             end
      default: state_d = IDLE;
    endcase
    if (wrap && bus.at_max) state_d = PAUSE;
  end

  // Output decode from the next state so every output lands registered.
  // clr only arises from IDLE/PAUSE where wrap cannot occur, so it never
  // coincides with tick_en.
  always_comb begin
    out_d         = '0;
    out_d.clr     = clr_d;
    out_d.freeze  = (state_d == LAP);
    out_d.tick_en = wrap && !bus.at_max &&
                    ((state_d == RUN) || (state_d == LAP));
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
    end
  end

  assign bus.state   = state_q;
  assign bus.tick_en = out_q.tick_en;
  assign bus.clr     = out_q.clr;
  assign bus.freeze  = out_q.freeze;

endmodule

// File: tb/tb_sw_run_ctrl.sv
// Scoreboard bench for sw_run_ctrl with DIV = 10.
module tb_sw_run_ctrl;
  import sw_pkg::*;

  localparam int SEL_ST = 0, SEL_FRZ = 1, SEL_CNT = 2, SEL_TCK = 3, SEL_CLR = 4;

  typedef struct {
    int cyc;
    int sel;
    int val;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  bit   mon_en = 1'b0;
  bit   done = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;

  exp_t exp_q[$];
  int   tick_q[$];
  int   clr_q[$];

  sw_run_ctrl_if bus ();

  sw_run_ctrl #(.CLK_HZ(10), .TICK_HZ(1), .DIV_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic string sel_name(input int sel);
    case (sel)
      SEL_ST:  return "state";
      SEL_FRZ: return "freeze";
      SEL_CNT: return "count";
      SEL_TCK: return "tick_en";
      default: return "clr";
    endcase
  endfunction

  function automatic int actual(input int sel);
    case (sel)
      SEL_ST:  return int'(bus.state);
      SEL_FRZ: return int'(bus.freeze);
      SEL_CNT: return int'(dut.u_pre.count);
      SEL_TCK: return int'(bus.tick_en);
      default: return int'(bus.clr);
    endcase
  endfunction

  task automatic ex(input int c, input int sel, input int v);
    exp_t e;
    e.cyc = c; e.sel = sel; e.val = v;
    exp_q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic at(input int n);
    while (cyc < n) step();
  endtask

  task automatic press(input bit ss, input bit lc);
    bus.btn_ss = ss; bus.btn_lc = lc;
    step();
    bus.btn_ss = 1'b0; bus.btn_lc = 1'b0;
  endtask

  // Monitor: level checks at their cycle, plus tick_en/clr pulse events.
  always @(negedge clk) begin
    if (mon_en) begin
      for (int i = exp_q.size() - 1; i >= 0; i--) begin
        if (exp_q[i].cyc <= cyc) begin
          n_vec++;
          if (exp_q[i].cyc < cyc) begin
            n_err++;
            $display("FAIL %s @%0d: check skipped (now %0d), want %0d",
                     sel_name(exp_q[i].sel), exp_q[i].cyc, cyc, exp_q[i].val);
          end else if (actual(exp_q[i].sel) != exp_q[i].val) begin
            n_err++;
            $display("FAIL %s @%0d: got %0d, want %0d", sel_name(exp_q[i].sel),
                     cyc, actual(exp_q[i].sel), exp_q[i].val);
          end
          exp_q.delete(i);
        end
      end
      while (tick_q.size() > 0 && tick_q[0] < cyc) begin
        n_vec++; n_err++;
        $display("FAIL tick_missing: got none at %0d, want tick_en=1", tick_q[0]);
        void'(tick_q.pop_front());
      end
      if (bus.tick_en === 1'b1) begin
        n_vec++;
        if (tick_q.size() > 0 && tick_q[0] == cyc) void'(tick_q.pop_front());
        else begin
          n_err++;
          $display("FAIL tick_extra: got tick_en=1 at %0d, want 0", cyc);
        end
      end
      while (clr_q.size() > 0 && clr_q[0] < cyc) begin
        n_vec++; n_err++;
        $display("FAIL clr_missing: got none at %0d, want clr=1", clr_q[0]);
        void'(clr_q.pop_front());
      end
      if (bus.clr === 1'b1) begin
        n_vec++;
        if (clr_q.size() > 0 && clr_q[0] == cyc) void'(clr_q.pop_front());
        else begin
          n_err++;
          $display("FAIL clr_extra: got clr=1 at %0d, want 0", cyc);
        end
      end
      if (done) begin
        n_vec++;
        if (exp_q.size() + tick_q.size() + clr_q.size() != 0) begin
          n_err++;
          $display("FAIL drain: got %0d pending expectations, want 0",
                   exp_q.size() + tick_q.size() + clr_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
      end
    end
  end

  initial begin
    #20000;
    $display("FAIL watchdog: got no finish by %0t, want finish", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    bus.btn_ss = 1'b0; bus.btn_lc = 1'b0; bus.at_max = 1'b0;
    at(3);
    ex(3, SEL_ST, 0); ex(3, SEL_FRZ, 0); ex(3, SEL_CNT, 0);
    ex(3, SEL_TCK, 0); ex(3, SEL_CLR, 0);
    mon_en = 1'b1;
    reset  = 1'b0;

    // 1: start, ticks every DIV cycles
    at(5);
    ex(6, SEL_ST, 1); ex(6, SEL_CNT, 0); ex(17, SEL_TCK, 0);
    tick_q.push_back(16); tick_q.push_back(26); tick_q.push_back(36);
    press(1, 0);

    // 2: pause at count 4, phase held, resume
    at(40);
    ex(40, SEL_CNT, 4); ex(41, SEL_ST, 2); ex(41, SEL_CNT, 5); ex(61, SEL_CNT, 5);
    press(1, 0);
    at(61);
    ex(62, SEL_ST, 1); ex(62, SEL_CNT, 5);
    tick_q.push_back(67); tick_q.push_back(77);
    tick_q.push_back(87); tick_q.push_back(97);
    press(1, 0);

    // 3: lap hold, release, pause, clear
    at(70);
    ex(71, SEL_ST, 3); ex(71, SEL_FRZ, 1);
    press(0, 1);
    at(100);
    ex(101, SEL_ST, 1); ex(101, SEL_FRZ, 0);
    press(0, 1);
    at(103);
    ex(104, SEL_ST, 2); ex(104, SEL_CNT, 7);
    press(1, 0);
    ex(105, SEL_ST, 0); ex(105, SEL_CLR, 1); ex(105, SEL_CNT, 0); ex(106, SEL_CLR, 0);
    clr_q.push_back(105);
    press(0, 1);

    // 4: overflow in RUN, then overflow in LAP
    at(110);
    ex(111, SEL_ST, 1);
    press(1, 0);
    at(115);
    ex(121, SEL_ST, 2); ex(121, SEL_TCK, 0); ex(121, SEL_FRZ, 0); ex(121, SEL_CNT, 0);
    bus.at_max = 1'b1;
    at(122);
    bus.at_max = 1'b0;
    at(125);
    ex(126, SEL_ST, 1);
    press(1, 0);
    at(127);
    ex(128, SEL_ST, 3); ex(128, SEL_FRZ, 1);
    press(0, 1);
    at(135);
    ex(135, SEL_CNT, 9); ex(136, SEL_ST, 2); ex(136, SEL_FRZ, 0); ex(136, SEL_TCK, 0);
    bus.at_max = 1'b1;
    step();
    bus.at_max = 1'b0;

    // button on a plain wrap: transition to LAP still gets its tick
    at(140);
    ex(141, SEL_ST, 1);
    press(1, 0);
    at(150);
    tick_q.push_back(151);
    ex(151, SEL_ST, 3); ex(151, SEL_FRZ, 1); ex(151, SEL_CNT, 0);
    press(0, 1);
    at(155);
    ex(156, SEL_ST, 2); ex(156, SEL_CNT, 5); ex(156, SEL_FRZ, 0);
    press(1, 0);
    at(157);
    ex(158, SEL_ST, 0); ex(158, SEL_CLR, 1); ex(158, SEL_CNT, 0);
    clr_q.push_back(158);
    press(0, 1);

    // 5: both buttons together
    at(160);
    ex(161, SEL_ST, 1); ex(161, SEL_CLR, 0);
    press(1, 1);
    at(163);
    ex(164, SEL_ST, 2); ex(164, SEL_CNT, 3); ex(164, SEL_FRZ, 0);
    press(1, 1);

    // 6: reset while in LAP at count 7
    at(166);
    ex(167, SEL_ST, 1); ex(167, SEL_CNT, 3);
    press(1, 0);
    ex(168, SEL_ST, 3); ex(168, SEL_CNT, 4); ex(168, SEL_FRZ, 1);
    press(0, 1);
    at(171);
    ex(171, SEL_CNT, 7);
    ex(172, SEL_ST, 0); ex(172, SEL_CNT, 0); ex(172, SEL_FRZ, 0);
    ex(172, SEL_TCK, 0); ex(172, SEL_CLR, 0);
    reset = 1'b1;
    step();
    reset = 1'b0;

    at(180);
    done = 1'b1;
  end

endmodule
